// File: rtl/carry_select_pkg.sv
// Shared types and helpers for the pipelined carry-select adder.
// Struct fields are sized for the largest supported geometry; the adder
// uses only the low BLK (or WIDTH) bits of each field.
package carry_select_pkg;

    // Upper bounds on the block and operand widths the shared types can carry.
    localparam int unsigned BLK_MAX   = 32;
    localparam int unsigned WIDTH_MAX = 128;

    // Stage-1 record for one block: results for carry-in 0 and carry-in 1.
    typedef struct packed {
        logic [BLK_MAX-1:0] sum0;
        logic [BLK_MAX-1:0] sum1;
        logic               c0;
        logic               c1;
    } s1_blk_t;

    // Stage-2 registered result.
    typedef struct packed {
        logic [WIDTH_MAX-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } s2_res_t;

    // Number of carry-select blocks for a given operand and block width.
    function automatic int unsigned nblk(input int unsigned width, input int unsigned blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/csa_block.sv
// Combinational BLK-bit carry-select block: computes the block sum and
// carry-out for both possible carry-in values.
module csa_block
    import carry_select_pkg::*;
#(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    output logic [BLK-1:0] sum0,
    output logic           c0,
    output logic [BLK-1:0] sum1,
    output logic           c1
);

    // Both speculative results are formed in parallel.
    always_comb begin
        {c0, sum0} = {1'b0, x} + {1'b0, y};
        {c1, sum1} = {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, 1'b1};
    end

endmodule

// File: rtl/carry_select_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
// Stage 1 precomputes every block for both carry-in values; stage 2 walks the
// select chain and registers sum, cout and signed overflow.
// Optional feature macro: CSA_SUB_EN adds a `sub` port (b inverted in stage 1).
module carry_select_adder_pipe
    import carry_select_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NBLK = nblk(WIDTH, BLK);

    // Reject geometries the block split or the shared types cannot represent.
    if ((WIDTH % BLK) != 0 || BLK < 2 || BLK > WIDTH || BLK > BLK_MAX ||
        WIDTH > WIDTH_MAX) begin : g_bad_cfg
        $error("carry_select_adder_pipe: WIDTH must be a multiple of BLK, 2 <= BLK <= WIDTH");
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic adv1;
    logic adv2;
    logic in_fire;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    // ------------------------------------------------------------------
    // Operand fold
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;

`ifdef CSA_SUB_EN
    assign b_eff = sub ? ~b : b;
`else
    assign b_eff = b;
`endif

    // ------------------------------------------------------------------
    // Stage 1 precompute
    // ------------------------------------------------------------------
    logic [BLK-1:0] blk0_sum;
    logic           blk0_c;
    s1_blk_t        blk_d [NBLK];

    // Block 0 sees the real carry-in, so it is resolved outright by a ripple.
    always_comb begin
        logic c;
        c        = cin;
        blk0_sum = '0;
        for (int i = 0; i < int'(BLK); i++) begin
            blk0_sum[i] = a[i] ^ b_eff[i] ^ c;
            c           = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
        blk0_c = c;
    end

    // Entry 0 carries the resolved block; its carry-in-1 half is never selected.
    assign blk_d[0] = '{sum0: BLK_MAX'(blk0_sum), sum1: '0, c0: blk0_c, c1: 1'b0};

    for (genvar k = 1; k < int'(NBLK); k++) begin : g_blk
        logic [BLK-1:0] sum_ci0;
        logic [BLK-1:0] sum_ci1;
        logic           cy_ci0;
        logic           cy_ci1;

        csa_block #(
            .BLK (BLK)
        ) u_csa (
            .x    (a[k*BLK +: BLK]),
            .y    (b_eff[k*BLK +: BLK]),
            .sum0 (sum_ci0),
            .c0   (cy_ci0),
            .sum1 (sum_ci1),
            .c1   (cy_ci1)
        );

        assign blk_d[k] = '{sum0: BLK_MAX'(sum_ci0), sum1: BLK_MAX'(sum_ci1),
                            c0: cy_ci0, c1: cy_ci1};
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    s1_blk_t s1_blk [NBLK];
    logic    s1_msb_a;
    logic    s1_msb_b;

    // Stage-1 occupancy: refilled from the input whenever the stage may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // Stage-1 payload loads only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NBLK); k++) begin
                s1_blk[k] <= '0;
            end
            s1_msb_a <= 1'b0;
            s1_msb_b <= 1'b0;
        end else if (in_fire) begin
            s1_blk   <= blk_d;
            s1_msb_a <= a[WIDTH-1];
            s1_msb_b <= b_eff[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 select chain
    // ------------------------------------------------------------------
    s2_res_t s2_res_d;
    s2_res_t s2_q;

    // Each block's carry-out picks the next block's speculative result.
    always_comb begin
        logic carry;
        s2_res_d                = '0;
        s2_res_d.sum[BLK-1:0]   = s1_blk[0].sum0[BLK-1:0];
        carry                   = s1_blk[0].c0;
        for (int k = 1; k < int'(NBLK); k++) begin
            s2_res_d.sum[k*BLK +: BLK] = carry ? s1_blk[k].sum1[BLK-1:0]
                                               : s1_blk[k].sum0[BLK-1:0];
            carry = carry ? s1_blk[k].c1 : s1_blk[k].c0;
        end
        s2_res_d.cout = carry;
        s2_res_d.ovf  = (s1_msb_a == s1_msb_b) && (s2_res_d.sum[WIDTH-1] != s1_msb_a);
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------

    // Stage-2 occupancy follows stage 1 whenever the consumer lets it move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
        end
    end

    // Stage-2 result loads only when a valid stage-1 beat moves forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_q <= '0;
        end else if (s1_valid && adv2) begin
            s2_q <= s2_res_d;
        end
    end

    assign sum  = s2_q.sum[WIDTH-1:0];
    assign cout = s2_q.cout;
    assign ovf  = s2_q.ovf;

endmodule
